// File: rtl/bram_rw_if.sv
// Bundles the engine's software-facing control/status and its BRAM port.
// The slave side is the engine; the master side is software plus the RAM.
interface bram_rw_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] start_addr;
  logic [31:0]       len;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] step;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] rd_sum;

  logic              bram_rst;
  logic              bram_en;
  logic [BYTES-1:0]  bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wrdata;
  logic [DATA_W-1:0] bram_rddata;

  modport master (
    output start, abort, mode, start_addr, len, seed, step, bram_rddata,
    input  busy, done, error, rd_sum,
    input  bram_rst, bram_en, bram_we, bram_addr, bram_wrdata
  );

  modport slave (
    input  start, abort, mode, start_addr, len, seed, step, bram_rddata,
    output busy, done, error, rd_sum,
    output bram_rst, bram_en, bram_we, bram_addr, bram_wrdata
  );
endinterface

// File: rtl/bram_rw_engine.sv
// BRAM test engine: burst read, write or read-then-write over a byte range,
// with an arithmetic write pattern, a read checksum, abort and error status.
module bram_rw_engine #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  bram_rw_if.slave bus
);

  localparam int BYTES   = DATA_W / 8;
  localparam int ALIGN_B = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic [31:0]       n_q;
  logic [31:0]       cnt_q;
  logic              error_q;
  logic [READ_LAT-1:0] vld_p;
  logic [DATA_W-1:0] rd_sum_q;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_q;
  logic [DATA_W-1:0] step_q;

  logic              active;
  logic              accept;
  logic              abort_hit;
  logic              illegal;
  logic              last;
  logic [ADDR_W-1:0] base_in;
  logic [31:0]       n_in;

  function automatic logic req_illegal(input logic [1:0] m, input logic [31:0] l);
    return (m == 2'd3) || (l == 32'd0) || ((l % 32'(BYTES)) != 32'd0);
  endfunction

  assign active    = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_WRITE);
  assign accept    = (state_q == S_IDLE) && bus.start;
  assign abort_hit = active && bus.abort;
  assign illegal   = req_illegal(bus.mode, bus.len);
  assign last      = (cnt_q == 32'd1);
  assign base_in   = (bus.start_addr >> ALIGN_B) << ALIGN_B;
  assign n_in      = bus.len / 32'(BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (illegal)               state_d = S_FIN;
          else if (bus.mode == 2'd1) state_d = S_WRITE;
          else                       state_d = S_READ;
        end
      end
      S_READ: begin
        if (bus.abort)  state_d = S_FIN;
        else if (last)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.abort)  state_d = S_FIN;
        else if (last)  state_d = (mode_q == 2'd2) ? S_WRITE : S_FIN;
      end
      S_WRITE: begin
        if (bus.abort || last) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // cnt_q holds the cycles remaining in the current burst or drain phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 2'd0;
      n_q     <= 32'd0;
      cnt_q   <= 32'd0;
      error_q <= 1'b0;
    end else if (accept) begin
      mode_q  <= bus.mode;
      n_q     <= n_in;
      cnt_q   <= n_in;
      error_q <= illegal;
    end else begin
      if (abort_hit) error_q <= 1'b1;
      case (state_q)
        S_READ:  cnt_q <= last ? 32'(READ_LAT) : cnt_q - 32'd1;
        S_DRAIN: cnt_q <= last ? n_q : cnt_q - 32'd1;
        S_WRITE: cnt_q <= cnt_q - 32'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // read-return pipeline: vld_p[k] marks a word arriving k+1 cycles after its enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p    <= '0;
      rd_sum_q <= '0;
    end else begin
      if (abort_hit) vld_p <= '0;
      else           vld_p <= (vld_p << 1) | READ_LAT'(state_q == S_READ);
      if (accept)
        rd_sum_q <= '0;
      else if (vld_p[READ_LAT-1] && !abort_hit)
        rd_sum_q <= rd_sum_q + bus.bram_rddata;
    end
  end

  // address and pattern generators; outputs are gated by state so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q <= base_in;
      addr_q <= base_in;
      wr_q   <= bus.seed;
      step_q <= bus.step;
    end else begin
      if (state_q == S_READ || state_q == S_WRITE)
        addr_q <= addr_q + ADDR_W'(BYTES);
      if (state_q == S_DRAIN && state_d == S_WRITE)
        addr_q <= base_q;
      if (state_q == S_WRITE)
        wr_q <= wr_q + step_q;
    end
  end

  assign bus.busy        = active;
  assign bus.done        = (state_q == S_FIN);
  assign bus.error       = error_q;
  assign bus.rd_sum      = rd_sum_q;
  assign bus.bram_rst    = 1'b0;
  assign bus.bram_en     = (state_q == S_READ) || (state_q == S_WRITE);
  assign bus.bram_we     = (state_q == S_WRITE) ? '1 : '0;
  assign bus.bram_addr   = bus.bram_en ? addr_q : '0;
  assign bus.bram_wrdata = (state_q == S_WRITE) ? wr_q : '0;

endmodule

// File: tb/tb_bram_rw_engine.sv
// Bench for bram_rw_engine: three configurations (32b/lat1, 64b/lat1, 32b/lat3)
// share one BRAM model; a cycle-table model built from the timing rules predicts outputs.
module tb_bram_rw_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_rw_if #(.DATA_W(32), .ADDR_W(32)) if_a ();
  bram_rw_if #(.DATA_W(64), .ADDR_W(32)) if_b ();
  bram_rw_if #(.DATA_W(32), .ADDR_W(32)) if_c ();

  bram_rw_engine #(.DATA_W(32), .ADDR_W(32), .READ_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  bram_rw_engine #(.DATA_W(64), .ADDR_W(32), .READ_LAT(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  bram_rw_engine #(.DATA_W(32), .ADDR_W(32), .READ_LAT(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic [2:0]  start_v = '0;
  logic        abort = 1'b0;
  logic [1:0]  mode = '0;
  logic [31:0] start_addr = '0;
  logic [31:0] len = '0;
  logic [63:0] seed = '0;
  logic [63:0] step = '0;
  int          sel = 0;

  assign if_a.start = start_v[0];  assign if_b.start = start_v[1];  assign if_c.start = start_v[2];
  assign if_a.abort = abort;       assign if_b.abort = abort;       assign if_c.abort = abort;
  assign if_a.mode  = mode;        assign if_b.mode  = mode;        assign if_c.mode  = mode;
  assign if_a.start_addr = start_addr; assign if_b.start_addr = start_addr; assign if_c.start_addr = start_addr;
  assign if_a.len = len;           assign if_b.len = len;           assign if_c.len = len;
  assign if_a.seed = seed[31:0];   assign if_b.seed = seed;         assign if_c.seed = seed[31:0];
  assign if_a.step = step[31:0];   assign if_b.step = step;         assign if_c.step = step[31:0];

  logic        o_en, o_busy, o_done, o_err;
  logic [7:0]  o_we;
  logic [31:0] o_addr;
  logic [63:0] o_wd, o_sum;

  always_comb begin
    o_en = 1'b0; o_busy = 1'b0; o_done = 1'b0; o_err = 1'b0;
    o_we = '0; o_addr = '0; o_wd = '0; o_sum = '0;
    case (sel)
      0: begin
        o_en = if_a.bram_en; o_we = 8'(if_a.bram_we); o_addr = if_a.bram_addr; o_wd = 64'(if_a.bram_wrdata);
        o_busy = if_a.busy; o_done = if_a.done; o_err = if_a.error; o_sum = 64'(if_a.rd_sum);
      end
      1: begin
        o_en = if_b.bram_en; o_we = if_b.bram_we; o_addr = if_b.bram_addr; o_wd = if_b.bram_wrdata;
        o_busy = if_b.busy; o_done = if_b.done; o_err = if_b.error; o_sum = if_b.rd_sum;
      end
      default: begin
        o_en = if_c.bram_en; o_we = 8'(if_c.bram_we); o_addr = if_c.bram_addr; o_wd = 64'(if_c.bram_wrdata);
        o_busy = if_c.busy; o_done = if_c.done; o_err = if_c.error; o_sum = 64'(if_c.rd_sum);
      end
    endcase
  end

  // BRAM model: registered read, extra output stages for longer latency, random data when idle
  logic [63:0] mem [logic [31:0]];
  logic [63:0] rd_p0 = '0, rd_p1 = '0, rd_p2 = '0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {~a, a ^ 32'h1357_9BDF};
  endfunction

  always @(posedge clk) begin
    if (o_en && o_we == 8'd0) rd_p0 <= mem_word(o_addr);
    else                      rd_p0 <= {$urandom, $urandom};
    rd_p1 <= rd_p0;
    rd_p2 <= rd_p1;
    if (o_en && o_we != 8'd0) mem[o_addr] = o_wd;
  end

  assign if_a.bram_rddata = rd_p0[31:0];
  assign if_b.bram_rddata = rd_p0;
  assign if_c.bram_rddata = rd_p2[31:0];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One transfer on configuration k; abort_c>0 raises abort in that cycle; hold keeps start high.
  task automatic run(input int k, input logic [1:0] m, input logic [31:0] a, input logic [31:0] l,
                     input logic [63:0] sd, input logic [63:0] st, input int abort_c, input bit hold);
    int B, rl, N, done_c, ws;
    bit legal, aborted;
    logic [31:0] base;
    logic [63:0] dmask, exp_sum;
    logic        e_en, e_err;
    logic [7:0]  e_we;
    logic [31:0] e_addr;
    logic [63:0] e_wd;
    B     = (k == 1) ? 8 : 4;
    rl    = (k == 2) ? 3 : 1;
    dmask = (k == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    base  = a & ~(32'(B) - 32'd1);
    legal = (m != 2'd3) && (l != 32'd0) && ((l % 32'(B)) == 32'd0);
    N     = int'(l / 32'(B));
    if (!legal)        done_c = 1;
    else if (m == 2'd0) done_c = N + rl + 1;
    else if (m == 2'd1) done_c = N + 1;
    else               done_c = 2 * N + rl + 1;
    aborted = legal && abort_c >= 1 && abort_c < done_c;
    if (aborted) done_c = abort_c + 1;
    exp_sum = '0;
    if (legal && m != 2'd1)
      for (int i = 0; i < N; i++) exp_sum += mem_word(base + 32'(i * B));
    exp_sum &= dmask;

    sel = k;
    @(posedge clk); #1;
    mode = m; start_addr = a; len = l; seed = sd; step = st;
    start_v = '0; start_v[k] = 1'b1;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk); #1;
      if (!hold || c > done_c) start_v = '0;
      abort = aborted && (c == abort_c);
      @(negedge clk);
      e_en = 1'b0; e_we = '0; e_addr = '0; e_wd = '0;
      if (legal && (!aborted || c <= abort_c)) begin
        if (m != 2'd1 && c <= N) begin
          e_en = 1'b1;
          e_addr = base + 32'(c - 1) * 32'(B);
        end
        ws = (m == 2'd1) ? 1 : N + rl + 1;
        if (m != 2'd0 && c >= ws && c < ws + N) begin
          e_en = 1'b1;
          e_we = (B == 8) ? 8'hFF : 8'h0F;
          e_addr = base + 32'(c - ws) * 32'(B);
          e_wd = (sd + 64'(c - ws) * st) & dmask;
        end
      end
      e_err = (c >= done_c) ? (!legal || aborted) : 1'b0;
      check_eq($sformatf("en k%0d c%0d", k, c), 64'(o_en), 64'(e_en));
      check_eq($sformatf("we k%0d c%0d", k, c), 64'(o_we), 64'(e_we));
      check_eq($sformatf("addr k%0d c%0d", k, c), 64'(o_addr), 64'(e_addr));
      check_eq($sformatf("wdata k%0d c%0d", k, c), o_wd, e_wd);
      check_eq($sformatf("done k%0d c%0d", k, c), 64'(o_done), 64'(c == done_c));
      check_eq($sformatf("busy k%0d c%0d", k, c), 64'(o_busy), 64'(c < done_c));
      check_eq($sformatf("error k%0d c%0d", k, c), 64'(o_err), 64'(e_err));
      if (c == done_c && !aborted)
        check_eq($sformatf("rd_sum k%0d", k), o_sum, exp_sum);
    end
    abort = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " en"},    64'(o_en), 64'd0);
    check_eq({tag, " we"},    64'(o_we), 64'd0);
    check_eq({tag, " addr"},  64'(o_addr), 64'd0);
    check_eq({tag, " wdata"}, o_wd, 64'd0);
    check_eq({tag, " busy"},  64'(o_busy), 64'd0);
    check_eq({tag, " done"},  64'(o_done), 64'd0);
    check_eq({tag, " error"}, 64'(o_err), 64'd0);
    check_eq({tag, " rd_sum"}, o_sum, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, B, ab;
    logic [1:0] m;
    logic [31:0] l;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check_eq("bram_rst", 64'(if_a.bram_rst), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // read-then-write over preloaded words 1..4
    mem[32'h100] = 64'd1; mem[32'h104] = 64'd2; mem[32'h108] = 64'd3; mem[32'h10C] = 64'd4;
    run(0, 2'd2, 32'h100, 32'd16, 64'd0, 64'd2, 0, 1'b0);
    // 64-bit write pattern wrapping through zero
    run(1, 2'd1, 32'h0, 32'd24, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    // illegal requests
    run(0, 2'd0, 32'h40, 32'd6, 64'd0, 64'd0, 0, 1'b0);
    run(0, 2'd0, 32'h40, 32'd0, 64'd0, 64'd0, 0, 1'b0);
    run(0, 2'd3, 32'h40, 32'd16, 64'd0, 64'd0, 0, 1'b0);
    // latency-3 read with checksum wrap
    mem[32'h200] = 64'hFFFF_FFFF; mem[32'h204] = 64'd2;
    run(2, 2'd0, 32'h200, 32'd8, 64'd0, 64'd0, 0, 1'b0);
    check_eq("sum_wrap", o_sum, 64'd1);
    // abort mid-read, then a full run with start held through busy and FIN
    run(0, 2'd2, 32'h300, 32'd64, 64'd5, 64'd3, 3, 1'b0);
    run(0, 2'd2, 32'h300, 32'd64, 64'd5, 64'd3, 0, 1'b1);
    // address wrap
    run(0, 2'd0, 32'hFFFF_FFF8, 32'd16, 64'd0, 64'd0, 0, 1'b0);
    run(0, 2'd1, 32'hFFFF_FFF8, 32'd16, 64'h1234, 64'h10, 0, 1'b0);

    // asynchronous reset during a write burst
    sel = 0;
    @(posedge clk); #1;
    mode = 2'd1; start_addr = 32'h400; len = 32'd64; seed = 64'd7; step = 64'd1; start_v = 3'b001;
    @(posedge clk); #1 start_v = '0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("pre_rst en", 64'(o_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst no_done", 64'(o_done), 64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");
    run(0, 2'd0, 32'h100, 32'd16, 64'd0, 64'd0, 0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      k = $urandom_range(0, 2);
      B = (k == 1) ? 8 : 4;
      if ($urandom_range(0, 7) == 0) m = 2'd3;
      else                           m = 2'($urandom_range(0, 2));
      l = 32'(B * $urandom_range(1, 8));
      if ($urandom_range(0, 9) == 0) l = l + 32'd1;
      if ($urandom_range(0, 11) == 0) l = 32'd0;
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
      run(k, m, $urandom, l, {$urandom, $urandom}, {$urandom, $urandom}, ab, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_rw_engine.md
# bram_rw_engine

Parametrised BRAM test engine sitting between the AXI-Lite register block and a PL block-RAM port, the next generation of the fixed 32-bit read-then-write controller. It runs a burst of read, write or read-then-write accesses over a byte range selected at start, and generates an arithmetic write pattern from a programmable seed and step. It also accumulates a checksum of all words read, supports abort, and reports busy, done and error status to software.

## Interface
- DATA_W, 32: data width in bits; multiple of 8, 8..128.
- ADDR_W, 32: byte-address width.
- READ_LAT, 1: BRAM read latency in cycles, 1..4.
- BYTES (localparam), DATA_W/8: bytes per word, also the address step.
- Reset is rst_n, asynchronous, active-low; clock is clk.
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous abort; honoured in any active state.
- mode  in  2  0 = read, 1 = write, 2 = read-then-write, 3 = illegal.
- start_addr  in  ADDR_W  first byte address; low log2(BYTES) bits ignored (forced 0).
- len  in  32  transfer length in bytes.
- seed  in  DATA_W  first write word.
- step  in  DATA_W  increment between successive write words.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky; cleared on next accepted start.
- rd_sum  out  DATA_W  sum of read words, modulo 2^DATA_W.
- bram_rst  out  1  constant 0.
- bram_en  out  1  BRAM enable.
- bram_we  out  BYTES  byte write enables.
- bram_addr  out  ADDR_W  byte address.
- bram_wrdata  out  DATA_W  write data.
- bram_rddata  in  DATA_W  read data.

## Operation
- States: IDLE, READ, DRAIN, WRITE, FIN.
- Reset values: all outputs 0; state IDLE.
- Start acceptance in IDLE with start=1 latches mode, base address, N = len/BYTES, seed and step. It also clears rd_sum and error and sets busy.
- Illegal request: len=0, len not a multiple of BYTES, or mode=3. The engine goes directly to FIN with error=1 and makes no BRAM access.
- READ: bram_en=1, bram_we=0 for N consecutive cycles; bram_addr = base + i*BYTES, i = 0..N-1.
- DRAIN: READ_LAT cycles with bram_en=0. Then mode 2 goes to WRITE; mode 0 goes to FIN.
- Read capture: bram_rddata is added to rd_sum exactly READ_LAT cycles after each READ enable cycle, N additions in total.
- WRITE: bram_en=1, bram_we all ones for N cycles; bram_addr as in READ; bram_wrdata = seed + i*step (mod 2^DATA_W). Then FIN.
- Mode 1 goes from start straight to WRITE.
- FIN: done=1 for one cycle, busy=0, bram_en/bram_we=0, bram_addr=0, bram_wrdata=0; state returns to IDLE.
- Abort in READ, DRAIN or WRITE: the next state is FIN with error=1, and bram_en/bram_we are low from the cycle after abort. Read data still in flight is discarded. Abort in IDLE or FIN is ignored.
- Address arithmetic wraps modulo 2^ADDR_W. The counter is 32-bit, so N up to 2^32/BYTES is supported.
- Asynchronous reset mid-transfer returns all outputs to reset values immediately; no done pulse.

## Timing
- Cycle 0 = start accepted. First bram_en is in cycle 1.
- Mode 0: enables in cycles 1..N; last capture at N+READ_LAT; done at N+READ_LAT+1.
- Mode 1: enables in cycles 1..N; done at N+1.
- Mode 2: reads in cycles 1..N; drain in N+1..N+READ_LAT; writes in N+READ_LAT+1..2N+READ_LAT; done at 2N+READ_LAT+1.
- Illegal request: done and error in cycle 1.
- rd_sum is final and stable when done is high. busy falls in the same cycle done rises.
- start while busy is ignored; start in the FIN cycle is ignored. The earliest next start is accepted in the cycle after done.

## Test plan
- Mode 2, DATA_W=32, READ_LAT=1, start_addr=0x100, len=16, seed=0, step=2, BRAM preloaded 1,2,3,4. Required: reads at 0x100..0x10C in cycles 1..4, rd_sum=10; writes 0,2,4,6 in cycles 6..9; done in cycle 10.
- Mode 1, DATA_W=64, start_addr=0x0, len=24, seed=0xFFFF_FFFF_FFFF_FFFF, step=1. Required: bram_we=0xFF; writes 0xFFFF_FFFF_FFFF_FFFF, 0, 1 at 0x0, 0x8, 0x10; done in cycle 4.
- Illegal requests len=6 (DATA_W=32), then len=0, then mode=3. Required for each: no bram_en; done and error in cycle 1; rd_sum=0.
- Mode 0, READ_LAT=3, len=8, data 0xFFFF_FFFF, 2. Required: rd_sum=1 (wrap); done in cycle 6.
- Abort in cycle 3 of a mode-2 transfer with len=64. Required: bram_en low from cycle 4, done and error in cycle 4. A following legal start clears error and runs fully.
- Address wrap: start_addr=0xFFFF_FFF8, len=16. Required: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4. Also assert rst_n mid-write: all outputs go to 0 immediately, with no done pulse.
